// File: rtl/agu_pair_gen_k2_if.sv
// rtl/agu_pair_gen_k2_if.sv - control and pair bus between the k2 AGU and its consumer
// inv_mode exists only when AGU_INTT_EN is defined.
interface agu_pair_gen_k2_if #(
  parameter int D_WIDTH = 32
);
  logic               start;
  logic               stall;
`ifdef AGU_INTT_EN
  logic               inv_mode;
`endif
  logic [D_WIDTH-1:0] Order_0;
  logic [D_WIDTH-1:0] Order_1;
  logic [D_WIDTH-1:0] l;
  logic               r_enable_k2;
  logic               AGU_done_k2;
  logic               busy;

`ifdef AGU_INTT_EN
  modport master (
    input  start, stall, inv_mode,
    output Order_0, Order_1, l, r_enable_k2, AGU_done_k2, busy
  );
  modport slave (
    output start, stall, inv_mode,
    input  Order_0, Order_1, l, r_enable_k2, AGU_done_k2, busy
  );
`else
  modport master (
    input  start, stall,
    output Order_0, Order_1, l, r_enable_k2, AGU_done_k2, busy
  );
  modport slave (
    output start, stall,
    input  Order_0, Order_1, l, r_enable_k2, AGU_done_k2, busy
  );
`endif
endinterface

// File: rtl/agu_pair_gen_k2.sv
// rtl/agu_pair_gen_k2.sv - NTT butterfly index-pair generator feeding the k2 order translator
// AGU_INTT_EN adds inv_mode (reverse stage order); undefined gives forward order only.
module agu_pair_gen_k2 #(
  parameter int D_WIDTH  = 32,
  parameter int DEGREE_W = 16,
  parameter int STAGES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  agu_pair_gen_k2_if.master bus
);

  localparam logic [DEGREE_W-1:0] ONE    = DEGREE_W'(1);
  localparam logic [DEGREE_W-1:0] DW_M1  = DEGREE_W'(DEGREE_W - 1);
  localparam logic [DEGREE_W-1:0] S_LAST = DEGREE_W'(STAGES - 1);
  localparam logic [DEGREE_W-1:0] J_LAST = DEGREE_W'((1 << (DEGREE_W - 1)) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nx;
  logic [DEGREE_W-1:0] s_q, s_nx;
  logic [DEGREE_W-1:0] j_q, j_nx;
  logic                inv_q;
  logic                issue, last_j, last_s;

  logic [DEGREE_W-1:0] shamt, half, lo, hi, pair0, pair1;
  logic [D_WIDTH-1:0]  o0_d, o1_d, l_d;
  logic                en_d, done_d;

`ifdef AGU_INTT_EN
  logic inv_nx;
`else
  assign inv_q = 1'b0;
`endif

  assign issue  = (state == RUN) && !bus.stall;
  assign last_j = (j_q == J_LAST);
  assign last_s = inv_q ? (s_q == '0) : (s_q == S_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      s_q             <= '0;
      j_q             <= '0;
`ifdef AGU_INTT_EN
      inv_q           <= 1'b0;
`endif
      bus.Order_0     <= '0;
      bus.Order_1     <= '0;
      bus.l           <= '0;
      bus.r_enable_k2 <= 1'b0;
      bus.AGU_done_k2 <= 1'b0;
    end else begin
      state           <= state_nx;
      s_q             <= s_nx;
      j_q             <= j_nx;
`ifdef AGU_INTT_EN
      inv_q           <= inv_nx;
`endif
      bus.Order_0     <= o0_d;
      bus.Order_1     <= o1_d;
      bus.l           <= l_d;
      bus.r_enable_k2 <= en_d;
      bus.AGU_done_k2 <= done_d;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s_q;
    j_nx     = j_q;
`ifdef AGU_INTT_EN
    inv_nx   = inv_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          j_nx     = '0;
`ifdef AGU_INTT_EN
          inv_nx   = bus.inv_mode;
          s_nx     = bus.inv_mode ? S_LAST : '0;
`else
          s_nx     = '0;
`endif
        end
      end
      RUN: begin
        if (issue) begin
          if (last_j) begin
            j_nx = '0;
            if (last_s) state_nx = IDLE;
            else        s_nx = inv_q ? (s_q - ONE) : (s_q + ONE);
          end else begin
            j_nx = j_q + ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Group index shifted up one extra bit leaves room for the upper half of each butterfly.
  always_comb begin
    shamt  = DW_M1 - s_q;
    half   = ONE << shamt;
    lo     = j_q & (half - ONE);
    hi     = (j_q >> shamt) << (shamt + ONE);
    pair0  = hi | lo;
    pair1  = pair0 + half;
    o0_d   = '0;
    o1_d   = '0;
    l_d    = '0;
    en_d   = 1'b0;
    done_d = 1'b0;
    if (issue) begin
      o0_d   = D_WIDTH'(pair0);
      o1_d   = D_WIDTH'(pair1);
      l_d    = D_WIDTH'(s_q);
      en_d   = 1'b1;
      done_d = last_j && last_s;
    end
  end

  assign bus.busy = (state == RUN);

endmodule
